// File: rtl/mips_pkg.sv
// Shared MIPS pipeline encodings: write-back source select, load size, zero register.
// The optional WB_LOAD_EXT_EN build uses LS_* to steer sub-word load alignment.
package mips_pkg;

  typedef enum logic [1:0] {
    WB_SRC_ALU  = 2'b00,
    WB_SRC_MEM  = 2'b01,
    WB_SRC_LINK = 2'b10,
    WB_SRC_ALT  = 2'b11
  } wb_src_e;

  typedef enum logic [1:0] {
    LS_WORD  = 2'b00,
    LS_HALF  = 2'b01,
    LS_BYTE  = 2'b10,
    LS_WORD2 = 2'b11
  } load_size_e;

  localparam int REG_ZERO = 0;

  // Returns the fill bit used when extending a sub-word value.
  function automatic logic ext_fill(input logic msb, input logic is_unsigned);
    return is_unsigned ? 1'b0 : msb;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM/WB boundary bundle: MEM-side instruction fields in, register-file/forwarding results out.
interface wb_stage_if #(
  parameter int B  = 32,
  parameter int D  = 5,
  parameter int CW = 32
);
  logic          stall;
  logic          flush;
  logic          in_valid;
  logic [B-1:0]  mem_data;
  logic [B-1:0]  alu_data;
  logic [B-1:0]  pc_link;
  logic [1:0]    wb_sel;
  logic          reg_write;
  logic [D-1:0]  dest;
  logic [1:0]    load_size;
  logic          load_unsigned;
  logic [1:0]    byte_off;
  logic          rf_we;
  logic [D-1:0]  rf_waddr;
  logic [B-1:0]  rf_wdata;
  logic          fwd_valid;
  logic [CW-1:0] retired;

  modport master (
    output stall, flush, in_valid, mem_data, alu_data, pc_link, wb_sel,
           reg_write, dest, load_size, load_unsigned, byte_off,
    input  rf_we, rf_waddr, rf_wdata, fwd_valid, retired
  );

  modport slave (
    input  stall, flush, in_valid, mem_data, alu_data, pc_link, wb_sel,
           reg_write, dest, load_size, load_unsigned, byte_off,
    output rf_we, rf_waddr, rf_wdata, fwd_valid, retired
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// Little-endian sub-word extraction on mem_data[31:0] with sign or zero extension to B bits.
module load_align
  import mips_pkg::*;
#(
  parameter int B = 32
) (
  input  logic [B-1:0] i_mem_data,
  input  logic [1:0]   i_load_size,
  input  logic         i_load_unsigned,
  input  logic [1:0]   i_byte_off,
  output logic [B-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_fill_b;
  logic        w_fill_h;

  // Lane selection; halfword ignores byte_off[0] since misalignment traps upstream.
  always_comb begin
    w_byte = i_mem_data[7:0];
    case (i_byte_off)
      2'd0:    w_byte = i_mem_data[7:0];
      2'd1:    w_byte = i_mem_data[15:8];
      2'd2:    w_byte = i_mem_data[23:16];
      2'd3:    w_byte = i_mem_data[31:24];
      default: w_byte = i_mem_data[7:0];
    endcase
    if (i_byte_off[1]) begin
      w_half = i_mem_data[31:16];
    end else begin
      w_half = i_mem_data[15:0];
    end
  end

  assign w_fill_b = ext_fill(w_byte[7], i_load_unsigned);
  assign w_fill_h = ext_fill(w_half[15], i_load_unsigned);

  always_comb begin
    o_data = i_mem_data;
    case (load_size_e'(i_load_size))
      LS_BYTE: o_data = {{(B-8){w_fill_b}}, w_byte};
      LS_HALF: o_data = {{(B-16){w_fill_h}}, w_half};
      default: o_data = i_mem_data;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, write-back source mux, $0-protected write enable and retire counter.
// Define WB_LOAD_EXT_EN to align and extend byte/halfword loads here instead of in MEM.
module wb_stage
  import mips_pkg::*;
#(
  parameter int B  = 32,
  parameter int D  = 5,
  parameter int CW = 32
) (
  input  logic       clk,
  input  logic       reset,
  wb_stage_if.slave  bus
);

  logic [B-1:0]  w_mem_data;
  logic [B-1:0]  w_wdata_next;
  logic          w_we_next;
  logic          w_retire;

  logic          r_we;
  logic [D-1:0]  r_waddr;
  logic [B-1:0]  r_wdata;
  logic [CW-1:0] r_retired;

`ifdef WB_LOAD_EXT_EN
  load_align #(.B(B)) u_load_align (
    .i_mem_data      (bus.mem_data),
    .i_load_size     (bus.load_size),
    .i_load_unsigned (bus.load_unsigned),
    .i_byte_off      (bus.byte_off),
    .o_data          (w_mem_data)
  );
`else
  logic w_unused_load_ctl;
  assign w_unused_load_ctl = ^{bus.load_size, bus.load_unsigned, bus.byte_off};
  assign w_mem_data        = bus.mem_data;
`endif

  // Source mux is evaluated on the incoming instruction so rf_wdata leaves a flop.
  always_comb begin
    w_wdata_next = bus.alu_data;
    case (wb_src_e'(bus.wb_sel))
      WB_SRC_MEM:  w_wdata_next = w_mem_data;
      WB_SRC_LINK: w_wdata_next = bus.pc_link;
      default:     w_wdata_next = bus.alu_data;
    endcase
  end

  assign w_we_next = bus.in_valid & bus.reg_write & (bus.dest != D'(REG_ZERO));
  assign w_retire  = bus.in_valid & ~bus.flush & ~bus.stall;

  // Pipeline register: reset > flush > stall > capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (bus.flush) begin
      r_we    <= 1'b0;
    end else if (!bus.stall) begin
      r_we    <= w_we_next;
      r_waddr <= bus.dest;
      r_wdata <= w_wdata_next;
    end
  end

  // Retire counter wraps silently at 2^CW.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CW'(1);
    end
  end

  assign bus.rf_we     = r_we;
  assign bus.fwd_valid = r_we;
  assign bus.rf_waddr  = r_waddr;
  assign bus.rf_wdata  = r_wdata;
  assign bus.retired   = r_retired;

endmodule

// File: tb/tb_wb_stage.sv
// Directed table-driven bench for wb_stage (CW = 4 so counter wrap is reachable).
module tb_wb_stage;

  localparam int B  = 32;
  localparam int D  = 5;
  localparam int CW = 4;

`ifdef WB_LOAD_EXT_EN
  localparam logic [31:0] EXP_B2S = 32'hFFFF_FFFF;
  localparam logic [31:0] EXP_B3S = 32'hFFFF_FF80;
  localparam logic [31:0] EXP_H0U = 32'h0000_7F01;
  localparam logic [31:0] EXP_B1U = 32'h0000_007F;
  localparam logic [31:0] EXP_H2S = 32'hFFFF_80FF;
`else
  localparam logic [31:0] EXP_B2S = 32'h80FF_7F01;
  localparam logic [31:0] EXP_B3S = 32'h80FF_7F01;
  localparam logic [31:0] EXP_H0U = 32'h80FF_7F01;
  localparam logic [31:0] EXP_B1U = 32'h80FF_7F01;
  localparam logic [31:0] EXP_H2S = 32'h80FF_7F01;
`endif

  typedef struct {
    logic        valid;
    logic [31:0] mem;
    logic [31:0] alu;
    logic [31:0] link;
    logic [1:0]  sel;
    logic        rw;
    logic [4:0]  dst;
    logic [1:0]  ls;
    logic        lu;
    logic [1:0]  off;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_ret;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  vec_t vecs [10];

  wb_stage_if #(.B(B), .D(D), .CW(CW)) bus_if ();

  wb_stage #(.B(B), .D(D), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic we, input logic [4:0] waddr,
                           input logic [31:0] wdata, input logic [3:0] ret);
    check({tag, ".rf_we"},     {31'd0, bus_if.rf_we},     {31'd0, we});
    check({tag, ".fwd_valid"}, {31'd0, bus_if.fwd_valid}, {31'd0, we});
    check({tag, ".rf_waddr"},  {27'd0, bus_if.rf_waddr},  {27'd0, waddr});
    check({tag, ".rf_wdata"},  bus_if.rf_wdata,           wdata);
    check({tag, ".retired"},   {28'd0, bus_if.retired},   {28'd0, ret});
  endtask

  task automatic drive(input logic st, input logic fl, input logic v,
                       input logic [31:0] mem, input logic [31:0] alu, input logic [31:0] link,
                       input logic [1:0] sel, input logic rw, input logic [4:0] dst,
                       input logic [1:0] ls, input logic lu, input logic [1:0] off);
    bus_if.stall         = st;
    bus_if.flush         = fl;
    bus_if.in_valid      = v;
    bus_if.mem_data      = mem;
    bus_if.alu_data      = alu;
    bus_if.pc_link       = link;
    bus_if.wb_sel        = sel;
    bus_if.reg_write     = rw;
    bus_if.dest          = dst;
    bus_if.load_size     = ls;
    bus_if.load_unsigned = lu;
    bus_if.byte_off      = off;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic v, input logic [31:0] mem, input logic [31:0] alu,
                              input logic [31:0] link, input logic [1:0] sel, input logic rw,
                              input logic [4:0] dst, input logic [1:0] ls, input logic lu,
                              input logic [1:0] off, input logic ewe, input logic [4:0] ewa,
                              input logic [31:0] ewd, input logic [3:0] eret);
    vec_t r;
    r.valid = v;   r.mem = mem; r.alu = alu; r.link = link; r.sel = sel;
    r.rw = rw;     r.dst = dst; r.ls = ls;   r.lu = lu;     r.off = off;
    r.exp_we = ewe; r.exp_waddr = ewa; r.exp_wdata = ewd; r.exp_ret = eret;
    return r;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    //             v     mem            alu            link           sel    rw    dst     ls     lu    off     we    waddr   wdata          ret
    vecs[0] = mk(1'b1, 32'h0,         32'h0000_1234, 32'h0,         2'b00, 1'b1, 5'd5,  2'b00, 1'b0, 2'd0, 1'b1, 5'd5,  32'h0000_1234, 4'd1);
    vecs[1] = mk(1'b1, 32'h0,         32'hDEAD_BEEF, 32'h0,         2'b00, 1'b1, 5'd0,  2'b00, 1'b0, 2'd0, 1'b0, 5'd0,  32'hDEAD_BEEF, 4'd2);
    vecs[2] = mk(1'b1, 32'h80FF_7F01, 32'h0,         32'h0,         2'b01, 1'b1, 5'd7,  2'b10, 1'b0, 2'd2, 1'b1, 5'd7,  EXP_B2S,       4'd3);
    vecs[3] = mk(1'b1, 32'h80FF_7F01, 32'h0,         32'h0,         2'b01, 1'b1, 5'd7,  2'b10, 1'b0, 2'd3, 1'b1, 5'd7,  EXP_B3S,       4'd4);
    vecs[4] = mk(1'b1, 32'h80FF_7F01, 32'h0,         32'h0,         2'b01, 1'b1, 5'd8,  2'b01, 1'b1, 2'd0, 1'b1, 5'd8,  EXP_H0U,       4'd5);
    vecs[5] = mk(1'b1, 32'h0,         32'h1111_2222, 32'h0040_0010, 2'b10, 1'b1, 5'd31, 2'b00, 1'b0, 2'd0, 1'b1, 5'd31, 32'h0040_0010, 4'd6);
    vecs[6] = mk(1'b1, 32'h5555_5555, 32'hA5A5_0001, 32'h0040_0020, 2'b11, 1'b1, 5'd3,  2'b00, 1'b0, 2'd0, 1'b1, 5'd3,  32'hA5A5_0001, 4'd7);
    vecs[7] = mk(1'b1, 32'h0,         32'h0000_0044, 32'h0,         2'b00, 1'b0, 5'd4,  2'b00, 1'b0, 2'd0, 1'b0, 5'd4,  32'h0000_0044, 4'd8);
    vecs[8] = mk(1'b1, 32'h80FF_7F01, 32'h0,         32'h0,         2'b01, 1'b1, 5'd9,  2'b10, 1'b1, 2'd1, 1'b1, 5'd9,  EXP_B1U,       4'd9);
    vecs[9] = mk(1'b1, 32'h80FF_7F01, 32'h0,         32'h0,         2'b01, 1'b1, 5'd10, 2'b01, 1'b0, 2'd3, 1'b1, 5'd10, EXP_H2S,       4'd10);

    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0, 2'b00, 1'b0, 2'd0);
    reset = 1'b1;
    step();
    step();
    check_out("reset", 1'b0, 5'd0, 32'h0, 4'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, vecs[i].valid, vecs[i].mem, vecs[i].alu, vecs[i].link, vecs[i].sel,
            vecs[i].rw, vecs[i].dst, vecs[i].ls, vecs[i].lu, vecs[i].off);
      step();
      check_out($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].exp_waddr,
                vecs[i].exp_wdata, vecs[i].exp_ret);
    end

    // An invalid instruction neither writes nor retires.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0066, 32'h0, 2'b00, 1'b1, 5'd6, 2'b00, 1'b0, 2'd0);
    step();
    check_out("invalid", 1'b0, 5'd6, 32'h0000_0066, 4'd10);

    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0011, 32'h0, 2'b00, 1'b1, 5'd9, 2'b00, 1'b0, 2'd0);
    step();
    check_out("pre_stall", 1'b1, 5'd9, 32'h0000_0011, 4'd11);

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_0100 + i, 32'h0, 2'b00, 1'b1, 5'd12 + 5'(i),
            2'b00, 1'b0, 2'd0);
      step();
      check_out($sformatf("stall%0d", i), 1'b1, 5'd9, 32'h0000_0011, 4'd11);
    end

    drive(1'b1, 1'b1, 1'b1, 32'h0, 32'h0000_0222, 32'h0, 2'b00, 1'b1, 5'd14, 2'b00, 1'b0, 2'd0);
    step();
    check("stall_flush.rf_we",     {31'd0, bus_if.rf_we},     32'd0);
    check("stall_flush.fwd_valid", {31'd0, bus_if.fwd_valid}, 32'd0);
    check("stall_flush.retired",   {28'd0, bus_if.retired},   32'd11);

    drive(1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0333, 32'h0, 2'b00, 1'b1, 5'd15, 2'b00, 1'b0, 2'd0);
    step();
    check("flush.rf_we",   {31'd0, bus_if.rf_we},   32'd0);
    check("flush.retired", {28'd0, bus_if.retired}, 32'd11);

    // Reset wins over a concurrent stall.
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_0444, 32'h0, 2'b00, 1'b1, 5'd16, 2'b00, 1'b0, 2'd0);
    reset = 1'b1;
    step();
    check_out("reset_stall", 1'b0, 5'd0, 32'h0, 4'd0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h0, 32'(i), 32'h0, 2'b00, 1'b0, 5'd2, 2'b00, 1'b0, 2'd0);
      step();
      if (i == 15) begin
        check("wrap16.retired", {28'd0, bus_if.retired}, 32'd0);
      end
    end
    check("wrap17.retired", {28'd0, bus_if.retired}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Parametrised write-back stage for the pipelined MIPS core.
- Registers the MEM/WB boundary and selects the write-back source: ALU result, memory data or link address.
- Optionally aligns and extends sub-word loads.
- Drives the register-file write port and the forwarding unit.
- Counts retired instructions.
- Supersedes the single-mux write-back; adds stall/flush handling, zero-register protection and a third source.

## Interface
Parameters:
- B, 32, data width (≥ 32)
- D, 5, register address width
- CW, 32, retired-instruction counter width

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold WB register contents
- flush  in  1  replace incoming instruction with a bubble
- in_valid  in  1  MEM stage presents a valid instruction
- mem_data  in  B  data memory read word
- alu_data  in  B  ALU result
- pc_link  in  B  return address (PC+8) for JAL/JALR/BGEZAL
- wb_sel  in  2  source select: 00 ALU, 01 MEM, 10 LINK, 11 ALU
- reg_write  in  1  instruction writes a register
- dest  in  D  destination register
- load_size  in  2  00 word, 01 halfword, 10 byte, 11 word
- load_unsigned  in  1  zero-extend sub-word load
- byte_off  in  2  load address bits [1:0]
- rf_we  out  1  register-file write enable
- rf_waddr  out  D  register-file write address
- rf_wdata  out  B  register-file write data
- fwd_valid  out  1  WB result is forwardable; equals rf_we
- retired  out  CW  retired-instruction count

## Operation
- Input capture happens at each rising clk edge, with priority in this order:
  - reset: all state cleared.
  - flush: valid bit cleared. Flush takes priority over stall.
  - stall: all state held.
  - otherwise: all inputs captured.
- Source select:
  - wb_sel 00 or 11: rf_wdata = alu_data.
  - wb_sel 01: rf_wdata = aligned load data.
  - wb_sel 10: rf_wdata = pc_link.
- Write enable:
  - rf_we = valid & reg_write & (dest != 0).
  - A write to $0 is suppressed; rf_waddr still shows the dest value.
  - When rf_we = 0, rf_wdata and rf_waddr still show the captured values; consumers ignore them.
- Load alignment uses little-endian lane order on mem_data[31:0]:
  - byte: lane = byte_off.
  - halfword: lane = byte_off[1]; byte_off[0] is ignored. Misalignment is trapped upstream, not here.
  - The extended result is B bits wide: sign bit replicated, or zeros when load_unsigned = 1.
  - Word loads pass mem_data unchanged.
- Retire counter:
  - Increments by 1 on every capture edge where in_valid = 1, flush = 0 and stall = 0.
  - Counts all valid instructions, including those with reg_write = 0.
  - Wraps from 2^CW−1 to 0 silently.

## Timing
- Latency: 1 cycle from input sample to rf_* outputs. All outputs are registered or a combinational function of registered state only. There is no input-to-output combinational path.
- Reset values: rf_we = 0, fwd_valid = 0, rf_waddr = 0, rf_wdata = 0, retired = 0.
- Reset asserted mid-stall or mid-flush clears state on that same edge.
- Stall held for N cycles: outputs are held for N cycles and rf_we stays at its captured value. The register-file write is idempotent, so repeated writes are harmless.
- stall and flush together: a bubble is loaded and the counter does not increment.
- The register file writes on the same edge that the next instruction is captured. Same-cycle read-after-write bypass belongs to the register file, not this block.

## Configuration
- WB_LOAD_EXT_EN defined: byte and halfword alignment and sign/zero extension are implemented as described in Operation.
- WB_LOAD_EXT_EN undefined:
  - load_size, load_unsigned and byte_off are ignored.
  - wb_sel 01 passes mem_data unchanged.
  - Sub-word handling becomes the memory stage's responsibility.

## Structure
- Shared package mips_pkg holds:
  - wb_sel encodings: WB_SRC_ALU, WB_SRC_MEM, WB_SRC_LINK.
  - load_size encodings: LS_WORD, LS_HALF, LS_BYTE.
  - The REG_ZERO constant.
- One sub-module, load_align: combinational extraction and extension. It is instantiated only under WB_LOAD_EXT_EN.
- The pipeline register, source mux, write-enable logic and counter live in wb_stage.

## Test plan
- Reset, then ALU write:
  - Assert reset for 2 cycles: all outputs are 0.
  - Then alu_data = 0x0000_1234, wb_sel = 00, dest = 5, reg_write = 1.
  - Next cycle: rf_we = 1, rf_waddr = 5, rf_wdata = 0x0000_1234, retired = 1.
- $0 protection:
  - dest = 0, reg_write = 1, in_valid = 1.
  - Result: rf_we = 0, fwd_valid = 0, retired increments.
- Load extension (macro on):
  - mem_data = 0x80FF_7F01, load_size = 10, byte_off = 2, load_unsigned = 0 → rf_wdata = 0xFFFF_FFFF.
  - Same inputs with byte_off = 3 → 0xFFFF_FF80.
  - load_size = 01, byte_off = 0, load_unsigned = 1 → 0x0000_7F01.
- Link:
  - wb_sel = 10, pc_link = 0x0040_0010, dest = 31.
  - Result: rf_waddr = 31, rf_wdata = 0x0040_0010.
- Stall and flush:
  - Hold stall for 3 cycles while inputs change: outputs and retired are unchanged.
  - Assert stall and flush together: rf_we = 0 next cycle, retired unchanged.
- Wrap: with CW = 4, issue 17 valid instructions → retired = 1.
